// File: rtl/dram_arbiter.sv
// dram_arbiter: two-master round-robin arbiter and sequencer in front of
// dram_memory. Full-word writes pass straight through; partial-strobe writes
// are turned into a read-modify-write, since the RAM only commits 4'b1111.
//
// Ports
//   iwClk, iwnRst           clock (rising edge), async active-low reset
//   iwReq*/iwWe*/iwAddr*/   per-master request: held until ack
//   iwWdata*/iwWstrb*
//   owAck*                  one-cycle completion pulse per master
//   owRdata*                registered read data, held until next read
//   owBusy                  high whenever the sequencer is not idle
//   owMem*/iwMemReadData    RAM side: combinational read, write commits on
//                           the falling edge of the cycle owMemWstrb is 1111

// One byte lane of the merge: new data where strobed, else the old word.
module dram_arbiter_byte_merge (
  input  logic       i_sel,
  input  logic [7:0] i_new,
  input  logic [7:0] i_old,
  output logic [7:0] o_byte
);
  assign o_byte = i_sel ? i_new : i_old;
endmodule

module dram_arbiter (
  input  logic        iwClk,
  input  logic        iwnRst,
  input  logic        iwReq0,
  input  logic        iwReq1,
  input  logic        iwWe0,
  input  logic        iwWe1,
  input  logic [31:0] iwAddr0,
  input  logic [31:0] iwAddr1,
  input  logic [31:0] iwWdata0,
  input  logic [31:0] iwWdata1,
  input  logic [3:0]  iwWstrb0,
  input  logic [3:0]  iwWstrb1,
  output logic        owAck0,
  output logic        owAck1,
  output logic [31:0] owRdata0,
  output logic [31:0] owRdata1,
  output logic        owBusy,
  output logic [31:0] owMemReadAddr,
  output logic [31:0] owMemWriteAddr,
  output logic [31:0] owMemWriteData,
  output logic [3:0]  owMemWstrb,
  input  logic [31:0] iwMemReadData
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_MERGE, S_DONE} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  state_t      r_state, w_next;
  req_t        r_req;
  req_t        w_req0, w_req1, w_sel;
  logic        r_owner;
  logic        r_last_gnt;
  logic [31:0] r_merge;
  logic [31:0] r_rdata0, r_rdata1;
  logic        w_gnt;
  logic        w_any_req;
  logic        w_full, w_partial;
  logic [NUM_LANES-1:0][7:0] w_merged;

  assign w_req0 = '{we: iwWe0, addr: {iwAddr0[31:2], 2'b00}, wdata: iwWdata0, wstrb: iwWstrb0};
  assign w_req1 = '{we: iwWe1, addr: {iwAddr1[31:2], 2'b00}, wdata: iwWdata1, wstrb: iwWstrb1};

  // Single requester wins outright; on a tie the master not granted last wins.
  assign w_any_req = iwReq0 | iwReq1;
  assign w_gnt     = (iwReq0 & iwReq1) ? ~r_last_gnt : iwReq1;
  assign w_sel     = w_gnt ? w_req1 : w_req0;

  assign w_full    = r_req.we && (r_req.wstrb == 4'b1111);
  assign w_partial = r_req.we && (r_req.wstrb != 4'b1111) && (r_req.wstrb != 4'b0000);

  for (genvar b = 0; b < NUM_LANES; b++) begin : g_lane
    dram_arbiter_byte_merge u_merge (
      .i_sel  (r_req.wstrb[b]),
      .i_new  (r_req.wdata[8*b +: 8]),
      .i_old  (r_merge[8*b +: 8]),
      .o_byte (w_merged[b])
    );
  end

  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Write strobe is decoded from the state, so an async reset in MERGE
  // drops it before the falling-edge commit.
  always_comb begin
    w_next         = r_state;
    owMemWstrb     = 4'b0000;
    owMemWriteData = r_req.wdata;
    unique case (r_state)
      S_IDLE:   if (w_any_req) w_next = S_ACCESS;
      S_ACCESS: begin
        if (w_full) owMemWstrb = 4'b1111;
        w_next = w_partial ? S_MERGE : S_DONE;
      end
      S_MERGE: begin
        owMemWstrb     = 4'b1111;
        owMemWriteData = w_merged;
        w_next         = S_DONE;
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      r_req      <= '0;
      r_owner    <= 1'b0;
      r_last_gnt <= 1'b1;
      r_merge    <= '0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      if (r_state == S_IDLE && w_any_req) begin
        r_req      <= w_sel;
        r_owner    <= w_gnt;
        r_last_gnt <= w_gnt;
      end
      if (r_state == S_ACCESS) begin
        if (!r_req.we) begin
          if (r_owner) r_rdata1 <= iwMemReadData;
          else         r_rdata0 <= iwMemReadData;
        end
        if (w_partial) r_merge <= iwMemReadData;
      end
    end
  end

  assign owAck0         = (r_state == S_DONE) && !r_owner;
  assign owAck1         = (r_state == S_DONE) &&  r_owner;
  assign owBusy         = (r_state != S_IDLE);
  assign owRdata0       = r_rdata0;
  assign owRdata1       = r_rdata1;
  assign owMemReadAddr  = r_req.addr;
  assign owMemWriteAddr = r_req.addr;

endmodule
